// File: rtl/timer_pkg.sv
// Shared definitions for the BCD stopwatch/timer family: FSM encoding,
// digit limit and a constant clog2 used to size the prescaler.
package timer_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_PAUSE = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam logic [3:0] BCD_MAX = 4'd9;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/bcd_up_digit.sv
// Single BCD digit up counter; wraps 9 -> 0 and flags carry while at 9.
module bcd_up_digit
    import timer_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       clear,
    input  logic       inc_en,
    output logic [3:0] out,
    output logic       carry
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out <= 4'd0;
        end else if (clear) begin
            out <= 4'd0;
        end else if (inc_en) begin
            out <= (out == BCD_MAX) ? 4'd0 : out + 4'd1;
        end
    end

    assign carry = (out == BCD_MAX);

endmodule

// File: rtl/sw_time_up.sv
// Three-digit BCD up-counting stopwatch with 1 s prescaler, start/stop/clear
// control and an optional terminal count (000 = free-running).
module sw_time_up
    import timer_pkg::*;
#(
    parameter int CLK_HZ    = 50000000,
    parameter int LIMIT_1   = 0,
    parameter int LIMIT_10  = 2,
    parameter int LIMIT_100 = 0
) (
    input  logic       CLK_I,
    input  logic       SW_RESET_I,
    input  logic       START_I,
    input  logic       STOP_I,
    input  logic       CLEAR_I,
    output logic [3:0] TIM_1,
    output logic [3:0] TIM_2,
    output logic [3:0] TIM_3,
    output logic       carry_1,
    output logic       carry_2,
    output logic       carry_3,
    output logic       pulse_1sec,
    output logic       TIMEOUT,
    output logic       RUNNING
);

    localparam int PW = clog2(CLK_HZ);
    localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_HZ - 1);
    localparam logic [11:0] LIMIT_BCD = {4'(LIMIT_100), 4'(LIMIT_10), 4'(LIMIT_1)};
    localparam bit LIMIT_ON = (LIMIT_BCD != 12'h000);

    logic [1:0]    state_reg, state_next;
    logic [PW-1:0] presc_reg, presc_next;
    logic          pulse_reg, pulse_next;
    logic          timeout_reg, timeout_next;

    logic [3:0]  digit [3];
    logic [2:0]  digit_carry;
    logic [3:0]  chain;
    logic [11:0] next_bcd;
    logic        tick;
    logic        hit;

    assign tick     = pulse_reg && (state_reg == ST_RUN);
    assign chain[0] = 1'b1;

    // Each digit advances on the tick when every lower digit sits at 9.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_digit
            bcd_up_digit u_digit (
                .clk    (CLK_I),
                .reset  (SW_RESET_I),
                .clear  (CLEAR_I),
                .inc_en (tick & chain[gi]),
                .out    (digit[gi]),
                .carry  (digit_carry[gi])
            );
            assign chain[gi+1] = chain[gi] & digit_carry[gi];
            assign next_bcd[gi*4 +: 4] = (tick & chain[gi])
                ? ((digit[gi] == BCD_MAX) ? 4'd0 : digit[gi] + 4'd1)
                : digit[gi];
        end
    endgenerate

    // The incrementing digits already land on the limit, so no load path is needed.
    assign hit = LIMIT_ON && tick && (next_bcd == LIMIT_BCD);

    always_ff @(posedge CLK_I or posedge SW_RESET_I) begin
        if (SW_RESET_I) begin
            state_reg   <= ST_IDLE;
            presc_reg   <= '0;
            pulse_reg   <= 1'b0;
            timeout_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            presc_reg   <= presc_next;
            pulse_reg   <= pulse_next;
            timeout_reg <= timeout_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        if (CLEAR_I) begin
            state_next = ST_IDLE;
        end else begin
            case (state_reg)
                ST_IDLE:  if (START_I) state_next = ST_RUN;
                ST_RUN: begin
                    if (hit)         state_next = ST_DONE;
                    else if (STOP_I) state_next = ST_PAUSE;
                end
                ST_PAUSE: if (START_I) state_next = ST_RUN;
                default:  state_next = ST_DONE;
            endcase
        end
    end

    always_comb begin
        presc_next   = presc_reg;
        pulse_next   = 1'b0;
        timeout_next = timeout_reg;
        if (CLEAR_I) begin
            presc_next   = '0;
            timeout_next = 1'b0;
        end else begin
            if (state_reg == ST_RUN) begin
                presc_next = (presc_reg == PRESC_LAST) ? '0 : presc_reg + PW'(1);
                pulse_next = (presc_reg == PRESC_LAST);
            end
            if (hit) begin
                timeout_next = 1'b1;
            end
        end
    end

    always_comb begin
        RUNNING = (state_reg == ST_RUN);
    end

    assign TIM_1      = digit[0];
    assign TIM_2      = digit[1];
    assign TIM_3      = digit[2];
    assign carry_1    = chain[1];
    assign carry_2    = chain[2];
    assign carry_3    = chain[3];
    assign pulse_1sec = pulse_reg;
    assign TIMEOUT    = timeout_reg;

endmodule
